iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div.sv | 109 ++++++++++
 tb/tb_iter_div.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// Iterative 32-bit divider: one restoring radix-2 step per clock, signed or unsigned.
// result_o = {remainder, quotient}; divide-by-zero gives all-ones quotient, dividend remainder.
module iter_div (
   input  logic        clk,
   input  logic        resetn,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient bits shift in
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic        negq_q, negq_d, negr_q, negr_d;
   logic [63:0] res_q, res_d;

   logic [31:0] abs1, abs2;
   logic [32:0] shifted, trial;

   always_comb begin
      abs1    = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
      abs2    = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
      shifted = {rem_q, dvd_q[31]};
      trial   = shifted - {1'b0, dvs_q};

      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      res_d   = res_q;

      case (state_q)
         IDLE: begin
            if (start_i && !annul_i) begin
               negq_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
               negr_d = signed_div_i & opdata1_i[31];
               dvs_d  = abs2;
               rem_d  = 32'h0;
               cnt_d  = 6'd0;
               if (opdata2_i == 32'h0) begin
                  // raw dividend kept: the zero-divisor remainder ignores signedness
                  dvd_d   = opdata1_i;
                  state_d = DIVZERO;
               end else begin
                  dvd_d   = abs1;
                  state_d = BUSY;
               end
            end
         end
         DIVZERO: begin
            if (annul_i) state_d = IDLE;
            else begin
               res_d   = {dvd_q, 32'hFFFF_FFFF};
               state_d = DONE;
            end
         end
         BUSY: begin
            if (annul_i) state_d = IDLE;
            else begin
               rem_d = trial[32] ? shifted[31:0] : trial[31:0];
               dvd_d = {dvd_q[30:0], ~trial[32]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  res_d   = {negr_q ? -rem_d : rem_d, negq_q ? -dvd_d : dvd_d};
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         dvd_q   <= 32'h0;
         dvs_q   <= 32'h0;
         rem_q   <= 32'h0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= 64'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
      end
   end

   assign result_o = res_q;
   assign ready_o  = (state_q == DONE);

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: latency, signed/unsigned results, zero divide, annul, reset.
module tb_iter_div;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = 32'h0;
   logic [31:0] opdata2_i = 32'h0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   int tests = 0;
   int fails = 0;

   iter_div dut (
      .clk          (clk),
      .resetn       (resetn),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive operands with start high and step through the start edge (T0).
   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk); #1;
   endtask

   // Count edges after T0 until ready_o; bounded.
   task automatic wait_ready(input string tag, input int exp_lat, input bit scramble);
      int k;
      k = 0;
      while (!ready_o && k < 40) begin
         if (scramble) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
         end
         @(posedge clk); #1;
         k++;
      end
      chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp);
      start_op(sgn, a, b);
      wait_ready(tag, lat, 1'b0);
      chk({tag, "_res"}, result_o, exp);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 64'(ready_o), 64'h0);
   endtask

   task automatic no_ready(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ready_o) seen++;
      end
      chk(tag, 64'(seen), 64'h0);
   endtask

   initial begin
      #2 resetn = 1'b0;
      #1;
      chk("rst_result", result_o, 64'h0);
      chk("rst_ready", 64'(ready_o), 64'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      run_div("u100_7",   1'b0, 32'd100,       32'd7,         32, {32'd2, 32'd14});
      run_div("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("u-7_2",    1'b0, 32'hFFFF_FFF9, 32'd2,         32, {32'd1, 32'h7FFF_FFFC});
      run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, {32'h0, 32'h8000_0000});
      run_div("u5_0",     1'b0, 32'd5,         32'd0,         1,  {32'd5, 32'hFFFF_FFFF});
      run_div("s-5_0",    1'b1, 32'hFFFF_FFFB, 32'd0,         1,  {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      run_div("u3_10",    1'b0, 32'd3,         32'd10,        32, {32'd3, 32'd0});
      run_div("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32, {32'd1, 32'hFFFF_FFFD});
      run_div("u9_3",     1'b0, 32'd9,         32'd3,         32, {32'd0, 32'd3});

      // annul during iteration 10
      start_op(1'b0, 32'd50, 32'd5);
      repeat (10) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk); #1;
      annul_i = 1'b0;
      chk("annul_ready", 64'(ready_o), 64'h0);
      chk("annul_hold", result_o, {32'd0, 32'd3});
      no_ready("annul_noready");
      chk("annul_hold2", result_o, {32'd0, 32'd3});
      run_div("u50_5", 1'b0, 32'd50, 32'd5, 32, {32'd0, 32'd10});

      // asynchronous reset during iteration 20
      start_op(1'b0, 32'd1000, 32'd3);
      repeat (20) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("arst_result", result_o, 64'h0);
      chk("arst_ready", 64'(ready_o), 64'h0);
      start_i = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      no_ready("arst_noready");
      run_div("u1_1", 1'b0, 32'd1, 32'd1, 32, {32'd0, 32'd1});

      // operands scrambled after the start edge; start held past ready restarts
      start_op(1'b0, 32'd1000, 32'd7);
      wait_ready("scr", 32, 1'b1);
      chk("scr_res", result_o, {32'd6, 32'd142});
      signed_div_i = 1'b0;
      opdata1_i    = 32'd20;
      opdata2_i    = 32'd6;
      @(posedge clk); #1;
      chk("restart_pulse", 64'(ready_o), 64'h0);
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_ready("restart", 32, 1'b0);
      chk("restart_res", result_o, {32'd2, 32'd3});
      @(posedge clk); #1;
      chk("restart_end", 64'(ready_o), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
